// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single main-memory line port between the
// dcache writeback/fill, icache fill and the DMA bus-request handshake.
//   clk, reset          : clock, asynchronous active-high reset
//   wb_req/addr/ack     : dcache writeback (line write) request/address/done pulse
//   dr_req/addr/ack     : dcache fill (line read) request/address/done pulse
//   if_req/addr/ack     : icache fill (line read) request/address/done pulse
//   dma_br, dma_bg      : DMA bus request in, bus grant out (level)
//   mem_addr/we/sel     : line-aligned address, write flag, owner (0 if,1 dr,2 wb,3 dma)
//   mem_active/mem_fire : access in progress / last access cycle (line moves)
module mem_port_arbiter #(
   parameter int unsigned LATENCY      = 4,
   parameter int unsigned DMA_MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_req,
   input  logic [15:0] wb_addr,
   output logic        wb_ack,
   input  logic        dr_req,
   input  logic [15:0] dr_addr,
   output logic        dr_ack,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   input  logic        dma_br,
   output logic        dma_bg,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [1:0]  mem_sel,
   output logic        mem_active,
   output logic        mem_fire
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_DMA} state_e;

   localparam logic [1:0] SEL_IF  = 2'd0;
   localparam logic [1:0] SEL_DR  = 2'd1;
   localparam logic [1:0] SEL_WB  = 2'd2;
   localparam logic [1:0] SEL_DMA = 2'd3;

   localparam logic [3:0] LAT  = 4'(LATENCY);
   localparam logic [7:0] MAXW = 8'(DMA_MAX_WAIT);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [1:0]  sel_q, sel_d;

   logic        dma_urgent;
   logic        pick_dr;
   logic        pick_if;
   logic        gnt_any;
   logic [1:0]  gnt_sel;
   logic [15:0] gnt_addr;

   // rr_q=0 favours dr, rr_q=1 favours if when both are asking
   assign dma_urgent = dma_br && (wait_q >= MAXW);
   assign pick_dr    = dr_req && (!if_req || !rr_q);
   assign pick_if    = if_req && (!dr_req ||  rr_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rr_q    <= 1'b0;
         wait_q  <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      addr_d   = addr_q;
      we_d     = we_q;
      sel_d    = sel_q;
      wait_d   = wait_q;
      gnt_any  = 1'b1;
      gnt_sel  = SEL_DMA;
      gnt_addr = wb_addr;

      priority case (1'b1)
         dma_urgent: gnt_sel = SEL_DMA;
         wb_req: begin
            gnt_sel  = SEL_WB;
            gnt_addr = wb_addr;
         end
         pick_dr: begin
            gnt_sel  = SEL_DR;
            gnt_addr = dr_addr;
         end
         pick_if: begin
            gnt_sel  = SEL_IF;
            gnt_addr = if_addr;
         end
         dma_br:  gnt_sel = SEL_DMA;
         default: gnt_any = 1'b0;
      endcase

      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               sel_d = gnt_sel;
               if (gnt_sel == SEL_DMA) begin
                  state_d = S_DMA;
                  we_d    = 1'b0;
               end else begin
                  state_d = S_ACCESS;
                  cnt_d   = 4'd1;
                  we_d    = (gnt_sel == SEL_WB);
                  addr_d  = {gnt_addr[15:2], 2'b00};
                  if (gnt_sel == SEL_DR) rr_d = 1'b1;
                  if (gnt_sel == SEL_IF) rr_d = 1'b0;
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == LAT) state_d = S_ACK;
            else              cnt_d   = cnt_q + 4'd1;
         end
         S_ACK:   state_d = S_IDLE;
         S_DMA:   if (!dma_br) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // waiting time of an ungranted DMA request, cleared once it wins
      if (!dma_br || state_q == S_DMA || state_d == S_DMA)
         wait_d = '0;
      else if (wait_q != 8'hFF)
         wait_d = wait_q + 8'd1;
   end

   always_comb begin
      mem_active = (state_q == S_ACCESS);
      mem_fire   = (state_q == S_ACCESS) && (cnt_q == LAT);
      dma_bg     = (state_q == S_DMA);
      wb_ack     = (state_q == S_ACK) && (sel_q == SEL_WB);
      dr_ack     = (state_q == S_ACK) && (sel_q == SEL_DR);
      if_ack     = (state_q == S_ACK) && (sel_q == SEL_IF);
      mem_addr   = addr_q;
      mem_we     = we_q;
      mem_sel    = sel_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the memory port arbiter.
module tb_mem_port_arbiter;

   localparam int LAT = 4;
   localparam int DMW = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_req, dr_req, if_req, dma_br;
   logic [15:0] wb_addr, dr_addr, if_addr;
   logic        wb_ack, dr_ack, if_ack, dma_bg;
   logic [15:0] mem_addr;
   logic        mem_we, mem_active, mem_fire;
   logic [1:0]  mem_sel;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LATENCY(LAT), .DMA_MAX_WAIT(DMW)) dut (
      .clk(clk), .reset(reset),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
      .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .dma_br(dma_br), .dma_bg(dma_bg),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_active(mem_active), .mem_fire(mem_fire)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   bit hold  = 0;

   // model: owner (-1 none, 0 if, 1 dr, 2 wb, 3 dma) and its grant cycle
   int          m_own  = -1;
   int          m_g    = 0;
   logic [15:0] m_addr = '0;
   bit          m_rr   = 0;
   int          m_wait = 0;
   logic e_act, e_fire, e_bg, e_wb, e_dr, e_if;

   // observations for the literal checks
   int          f_fire, f_bg, n_bgfire;
   int          f_ack[3];
   int          n_ack[3];
   logic        we_ack[3];
   logic [15:0] addr1;
   logic        we1;
   logic        bg_t[64];
   int          ord[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic void model_out();
      int e = cyc - m_g;
      e_act = 0; e_fire = 0; e_bg = 0;
      e_wb = 0; e_dr = 0; e_if = 0;
      if (m_own == 3) e_bg = 1;
      else if (m_own >= 0) begin
         if (e >= 1 && e <= LAT) e_act = 1;
         if (e == LAT) e_fire = 1;
         if (e == LAT + 1) begin
            if (m_own == 0) e_if = 1;
            if (m_own == 1) e_dr = 1;
            if (m_own == 2) e_wb = 1;
         end
      end
   endfunction

   function automatic void grant(int who, logic [15:0] a);
      m_own = who;
      m_g   = cyc;
      if (who < 3) m_addr = {a[15:2], 2'b00};
      if (who == 1) m_rr = 1;
      if (who == 0) m_rr = 0;
   endfunction

   function automatic void model_edge();
      int e = cyc - m_g;
      int nw;
      nw = (dma_br && m_own != 3) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      if (m_own < 0) begin
         if (dma_br && m_wait >= DMW) grant(3, 16'h0);
         else if (wb_req)             grant(2, wb_addr);
         else if (dr_req && if_req)   grant(m_rr ? 0 : 1, m_rr ? if_addr : dr_addr);
         else if (dr_req)             grant(1, dr_addr);
         else if (if_req)             grant(0, if_addr);
         else if (dma_br)             grant(3, 16'h0);
      end else if (m_own == 3) begin
         if (!dma_br) m_own = -1;
      end else if (e == LAT + 1) begin
         m_own = -1;
      end
      if (m_own == 3) nw = 0;
      m_wait = nw;
   endfunction

   task automatic compare();
      model_out();
      chk("bg", 32'(dma_bg), 32'(e_bg));
      chk("active", 32'(mem_active), 32'(e_act));
      chk("fire", 32'(mem_fire), 32'(e_fire));
      chk("wb_ack", 32'(wb_ack), 32'(e_wb));
      chk("dr_ack", 32'(dr_ack), 32'(e_dr));
      chk("if_ack", 32'(if_ack), 32'(e_if));
      chk("ack_onehot", 32'($countones({wb_ack, dr_ack, if_ack}) <= 1), 32'd1);
      if (m_own >= 0) chk("sel", 32'(mem_sel), 32'(m_own));
      if (m_own >= 0 && m_own < 3) begin
         chk("addr", 32'(mem_addr), 32'(m_addr));
         chk("we", 32'(mem_we), 32'(m_own == 2));
      end
   endtask

   task automatic clear_track();
      f_fire = -1; f_bg = -1; n_bgfire = 0;
      for (int i = 0; i < 3; i++) begin
         f_ack[i] = -1; n_ack[i] = 0; we_ack[i] = 1'bx;
      end
      for (int i = 0; i < 64; i++) bg_t[i] = 1'b0;
      ord.delete();
      t0 = cyc;
   endtask

   task automatic note_ack(int k);
      n_ack[k]++;
      if (f_ack[k] < 0) begin
         f_ack[k]  = cyc - t0;
         we_ack[k] = mem_we;
      end
      ord.push_back(k);
   endtask

   task automatic step();
      int t;
      @(negedge clk);
      t = cyc - t0;
      compare();
      if (mem_fire && f_fire < 0) f_fire = t;
      if (dma_bg && f_bg < 0) f_bg = t;
      if (dma_bg && mem_fire) n_bgfire++;
      if (t >= 0 && t < 64) bg_t[t] = dma_bg;
      if (t == 1) begin
         addr1 = mem_addr;
         we1   = mem_we;
      end
      if (if_ack) note_ack(0);
      if (dr_ack) note_ack(1);
      if (wb_ack) note_ack(2);
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      if (!hold) begin
         if (e_wb) wb_req = 1'b0;
         if (e_dr) dr_req = 1'b0;
         if (e_if) if_req = 1'b0;
      end
   endtask

   task automatic chk_zero(string nm);
      chk(nm, 32'({wb_ack, dr_ack, if_ack, dma_bg, mem_we, mem_active, mem_fire}), 32'd0);
      chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
      chk({nm, "_sel"}, 32'(mem_sel), 32'd0);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      wb_req = 1'b0; dr_req = 1'b0; if_req = 1'b0; dma_br = 1'b0;
      hold   = 0;
      #1;
      chk_zero("reset_out");
      m_own = -1; m_rr = 0; m_wait = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
   endtask

   initial begin
      reset = 1'b0;
      wb_req = 1'b0; dr_req = 1'b0; if_req = 1'b0; dma_br = 1'b0;
      wb_addr = '0; dr_addr = '0; if_addr = '0;
      #2;
      do_reset();

      // single fill
      clear_track();
      dr_req = 1'b1; dr_addr = 16'h0026;
      repeat (8) step();
      chk("fill_addr", 32'(addr1), 32'h0024);
      chk("fill_we", 32'(we1), 32'd0);
      chk("fill_fire_cyc", 32'(f_fire), 32'd4);
      chk("fill_ack_cyc", 32'(f_ack[1]), 32'd5);
      chk("fill_ack_cnt", 32'(n_ack[1]), 32'd1);

      // contention
      do_reset();
      clear_track();
      wb_req = 1'b1; dr_req = 1'b1; if_req = 1'b1;
      wb_addr = 16'h1237; dr_addr = 16'h4569; if_addr = 16'h789B;
      repeat (20) step();
      chk("cont_wb_ack", 32'(f_ack[2]), 32'd5);
      chk("cont_dr_ack", 32'(f_ack[1]), 32'd11);
      chk("cont_if_ack", 32'(f_ack[0]), 32'd17);
      chk("cont_wb_we", 32'(we_ack[2]), 32'd1);
      chk("cont_dr_we", 32'(we_ack[1]), 32'd0);
      chk("cont_if_we", 32'(we_ack[0]), 32'd0);

      // round-robin with continuous dr/if requests
      do_reset();
      clear_track();
      hold = 1;
      dr_req = 1'b1; if_req = 1'b1;
      repeat (24) step();
      chk("rr_count", 32'(ord.size()), 32'd4);
      if (ord.size() >= 4) begin
         chk("rr_0", 32'(ord[0]), 32'd1);
         chk("rr_1", 32'(ord[1]), 32'd0);
         chk("rr_2", 32'(ord[2]), 32'd1);
         chk("rr_3", 32'(ord[3]), 32'd0);
      end

      // DMA starvation guard
      do_reset();
      clear_track();
      hold = 1;
      dr_req = 1'b1; if_req = 1'b1; dma_br = 1'b1;
      repeat (16) step();
      dma_br = 1'b0;
      repeat (2) step();
      hold = 0;
      chk("dma_bg_rise", 32'(f_bg), 32'd13);
      chk("dma_no_fire", 32'(n_bgfire), 32'd0);
      chk("dma_bg_held", 32'(bg_t[16]), 32'd1);
      chk("dma_bg_drop", 32'(bg_t[17]), 32'd0);

      // reset in the middle of an access
      do_reset();
      clear_track();
      dr_req = 1'b1; dr_addr = 16'hBEEF;
      repeat (2) step();
      do_reset();
      clear_track();
      repeat (8) step();
      chk("rst_no_fire", 32'(f_fire), 32'hFFFF_FFFF);
      chk("rst_no_ack", 32'(n_ack[0] + n_ack[1] + n_ack[2]), 32'd0);
      clear_track();
      if_req = 1'b1; if_addr = 16'h0ABC;
      repeat (8) step();
      chk("rst_if_ack", 32'(f_ack[0]), 32'd5);

      // request dropped during the access
      do_reset();
      clear_track();
      dr_req = 1'b1; dr_addr = 16'h3333;
      repeat (2) step();
      dr_req = 1'b0;
      repeat (6) step();
      chk("cancel_fire", 32'(f_fire), 32'd4);
      chk("cancel_ack", 32'(f_ack[1]), 32'd5);

      // randomized traffic
      do_reset();
      clear_track();
      for (int n = 0; n < 4000; n++) begin
         if (!wb_req && m_own != 2 && $urandom_range(0, 7) == 0) wb_req = 1'b1;
         if (!dr_req && m_own != 1 && $urandom_range(0, 3) == 0) dr_req = 1'b1;
         if (!if_req && m_own != 0 && $urandom_range(0, 3) == 0) if_req = 1'b1;
         if (m_own >= 0 && m_own < 3 && cyc - m_g >= 1 && cyc - m_g <= LAT
             && $urandom_range(0, 7) == 0) begin
            if (m_own == 0) if_req = 1'b0;
            if (m_own == 1) dr_req = 1'b0;
            if (m_own == 2) wb_req = 1'b0;
         end
         if (dma_br) begin
            if ($urandom_range(0, (m_own == 3) ? 2 : 63) == 0) dma_br = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            dma_br = 1'b1;
         end
         wb_addr = 16'($urandom);
         dr_addr = 16'($urandom);
         if_addr = 16'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
